// File: rtl/quad_daq_if.sv
// DAQ req/grant stream bundle between an acquisition source and the arbiter.
// master: source side (drives data/valid/end/req); slave: arbiter side (drives grant).
interface quad_daq_if;
    logic [31:0] daq_data;
    logic        daq_valid;
    logic        daq_end;
    logic        daq_req;
    logic        daq_grant;

    modport master (
        output daq_data,
        output daq_valid,
        output daq_end,
        output daq_req,
        input  daq_grant
    );

    modport slave (
        input  daq_data,
        input  daq_valid,
        input  daq_end,
        input  daq_req,
        output daq_grant
    );
endinterface

// File: rtl/quad_daq.sv
// Quadrature encoder acquisition source: 4x decode into a 32-bit position,
// periodic snapshot of {pos, systime}, 3-word packet out on the DAQ stream.
// Ports: clk, rst_n (async, active-low), systime, enc_a/enc_b (raw pins),
//        enable, period (0 = no sampling), zero (clear pulse), daq (master).
module quad_daq #(
    parameter logic [7:0] DAQ_ID      = 8'h10,
    parameter int         PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            systime,
    input  logic                   enc_a,
    input  logic                   enc_b,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   zero,
    quad_daq_if.master             daq
);

    localparam logic [PERIOD_BITS-1:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, REQ, W0, W1, W2} state_t;

    state_t                 state;
    logic                   a_s1, a_s2, b_s1, b_s2;
    logic [1:0]             ab_prev;
    logic [1:0]             ab_cur;
    logic                   step_fwd, step_rev, step_bad;
    logic [31:0]            pos;
    logic                   err;
    logic [7:0]             drops;
    logic                   pending;
    logic [31:0]            snap_pos, snap_time;
    logic [PERIOD_BITS-1:0] timer;
    logic                   run, tick, drop_ev, emit_w0;

    assign ab_cur = {a_s2, b_s2};

    // Gray sequence 00->01->11->10->00 is forward
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        unique case ({ab_prev, ab_cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step_fwd = 1'b1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: step_rev = 1'b1;
            default: ;
        endcase
    end

    assign step_bad = (ab_prev ^ ab_cur) == 2'b11;

    assign run     = enable && (period != '0);
    assign tick    = run && (timer == '0);
    assign drop_ev = tick && pending;
    assign emit_w0 = (state == REQ) && daq.daq_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1    <= 1'b0;
            a_s2    <= 1'b0;
            b_s1    <= 1'b0;
            b_s2    <= 1'b0;
            ab_prev <= 2'b00;
            pos     <= '0;
        end else begin
            a_s1    <= enc_a;
            a_s2    <= a_s1;
            b_s1    <= enc_b;
            b_s2    <= b_s1;
            ab_prev <= ab_cur;
            if (zero)          pos <= '0;
            else if (step_fwd) pos <= pos + 32'd1;
            else if (step_rev) pos <= pos - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!run || timer == '0) begin
            timer <= period - ONE;
        end else begin
            timer <= timer - ONE;
        end
    end

    // Status is handed to W0 at the grant edge; events on that edge
    // start the next packet's tally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err   <= 1'b0;
            drops <= '0;
        end else if (emit_w0) begin
            err   <= step_bad;
            drops <= {7'd0, drop_ev};
        end else begin
            if (step_bad)                     err   <= 1'b1;
            if (drop_ev && drops != 8'hFF)    drops <= drops + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            snap_pos  <= '0;
            snap_time <= '0;
        end else if (tick && !pending) begin
            pending   <= 1'b1;
            snap_pos  <= pos;
            snap_time <= systime;
        end else if (state == W2) begin
            pending   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            daq.daq_data  <= '0;
            daq.daq_valid <= 1'b0;
            daq.daq_end   <= 1'b0;
            daq.daq_req   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending) begin
                        state       <= REQ;
                        daq.daq_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (daq.daq_grant) begin
                        state         <= W0;
                        daq.daq_valid <= 1'b1;
                        daq.daq_data  <= {DAQ_ID, drops, 15'd0, err};
                    end
                end
                W0: begin
                    state        <= W1;
                    daq.daq_data <= snap_time;
                end
                W1: begin
                    state        <= W2;
                    daq.daq_data <= snap_pos;
                    daq.daq_end  <= 1'b1;
                end
                W2: begin
                    state         <= IDLE;
                    daq.daq_data  <= '0;
                    daq.daq_valid <= 1'b0;
                    daq.daq_end   <= 1'b0;
                    daq.daq_req   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_daq.sv
// Self-checking bench for quad_daq: cycle-level reference model plus
// directed scenarios with hand-computed packet contents.
module tb_quad_daq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] systime = 32'h1000_0000;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] period = 24'd0;
    logic        zero = 1'b0;

    int checks = 0;
    int failures = 0;

    quad_daq_if bus();

    quad_daq #(.DAQ_ID(8'h10), .PERIOD_BITS(24)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .systime(systime),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .enable(enable),
        .period(period),
        .zero(zero),
        .daq(bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        systime = systime + 32'd3;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    function automatic int gi(logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] lut(int gg);
        case (gg)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Reference model. stage: 0 idle, 1 sample held, 2 requesting,
    // 3..5 emitting words 0..2. Pins reach the counter 3 edges late.
    logic [31:0] m_pos = 0;
    logic        m_err = 0;
    logic [7:0]  m_drops = 0;
    logic [23:0] m_tmr = 0;
    int          stage = 0;
    logic [1:0]  h0 = 0, h1 = 0, h2 = 0;
    logic [31:0] s_pos = 0, s_time = 0, w0 = 0;
    logic        m_tick, m_bad, m_drop, took;
    int          d;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pos = 0; m_err = 0; m_drops = 0; m_tmr = 0; stage = 0;
            h0 = 0; h1 = 0; h2 = 0; s_pos = 0; s_time = 0; w0 = 0;
        end else begin
            m_tick = 0;
            if (!enable || period == 0) begin
                m_tmr = period - 24'd1;
            end else if (m_tmr == 0) begin
                m_tick = 1;
                m_tmr = period - 24'd1;
            end else begin
                m_tmr = m_tmr - 24'd1;
            end
            d = (gi(h1) - gi(h2)) & 3;
            m_bad = (d == 2);
            m_drop = m_tick && (stage != 0);
            took = 0;
            case (stage)
                0: if (m_tick) begin
                    s_pos = m_pos; s_time = systime; stage = 1;
                end
                1: stage = 2;
                2: if (bus.daq_grant) begin
                    w0 = {8'h10, m_drops, 15'd0, m_err};
                    m_drops = {7'd0, m_drop};
                    m_err = m_bad;
                    took = 1;
                    stage = 3;
                end
                5: stage = 0;
                default: stage = stage + 1;
            endcase
            if (!took) begin
                if (m_drop && m_drops != 8'hFF) m_drops = m_drops + 8'd1;
                if (m_bad) m_err = 1;
            end
            if (zero)        m_pos = 0;
            else if (d == 1) m_pos = m_pos + 32'd1;
            else if (d == 3) m_pos = m_pos - 32'd1;
            h2 = h1; h1 = h0; h0 = {enc_a, enc_b};
        end
    end

    function automatic logic [31:0] exp_data(int st);
        case (st)
            3:       return w0;
            4:       return s_time;
            5:       return s_pos;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("req",   bus.daq_req,   stage >= 2);
            chk("valid", bus.daq_valid, stage >= 3);
            chk("end",   bus.daq_end,   stage == 5);
            chk("data",  bus.daq_data,  exp_data(stage));
        end
    end

    // Completed packets, for the literal checks
    logic [31:0] cap [3];
    logic [31:0] last [3];
    int          widx = 0;
    int          npkt = 0;

    initial forever begin
        @(negedge clk);
        if (bus.daq_valid) begin
            if (widx < 3) cap[widx] = bus.daq_data;
            widx++;
            if (bus.daq_end) begin
                last = cap;
                npkt++;
                widx = 0;
            end
        end else begin
            widx = 0;
        end
    end

    int g = 0;
    logic [31:0] t_rec;

    task automatic qstep(input int dir);
        g = (g + dir + 4) % 4;
        {enc_a, enc_b} = lut(g);
        repeat (8) @(negedge clk);
    endtask

    task automatic arm(input logic [23:0] p);
        enable = 0;
        period = p;
        @(negedge clk);
        enable = 1;
    endtask

    task automatic wait_pkt(input int budget, input string nm);
        int n0;
        int i;
        n0 = npkt;
        i = 0;
        while (npkt == n0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (npkt == n0) begin
            checks++;
            failures++;
            $display("FAIL %s: no packet within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_sig(input int budget, input string nm,
                            input bit want_valid);
        int i;
        i = 0;
        while (!(want_valid ? bus.daq_valid : bus.daq_req)
               && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s: signal not seen within %0d cycles",
                     nm, budget);
        end
    endtask

    initial begin
        bus.daq_grant = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  bus.daq_data,  32'd0);
        chk("rst_valid", bus.daq_valid, 1'b0);
        chk("rst_end",   bus.daq_end,   1'b0);
        chk("rst_req",   bus.daq_req,   1'b0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Forward/reverse count
        bus.daq_grant = 1;
        for (int i = 0; i < 10; i++) qstep(1);
        for (int i = 0; i < 3; i++) qstep(-1);
        arm(24'd1000);
        wait_pkt(1200, "fr_pkt");
        chk("fr_w2", last[2], 32'h0000_0007);
        chk("fr_w0", last[0], 32'h1000_0000);
        enable = 0;

        // Illegal transition and wrap below zero
        zero = 1;
        @(negedge clk);
        zero = 0;
        repeat (4) @(negedge clk);
        qstep(-1);
        qstep(2);
        arm(24'd20);
        wait_pkt(100, "ill_pkt1");
        chk("ill_w2", last[2], 32'hFFFF_FFFF);
        chk("ill_w0", last[0], 32'h1000_0001);
        wait_pkt(100, "ill_pkt2");
        chk("ill_w0_next", last[0], 32'h1000_0000);
        enable = 0;
        repeat (5) @(negedge clk);

        // Handshake timing with grant withheld
        bus.daq_grant = 0;
        arm(24'd20);
        wait_sig(100, "hs_req", 1'b0);
        enable = 0;
        repeat (20) @(negedge clk);
        chk("hs_req_wait",   bus.daq_req,   1'b1);
        chk("hs_valid_wait", bus.daq_valid, 1'b0);
        bus.daq_grant = 1;
        @(negedge clk);
        chk("hs_v0", bus.daq_valid, 1'b1);
        chk("hs_e0", bus.daq_end,   1'b0);
        chk("hs_d0", bus.daq_data,  32'h1000_0000);
        @(negedge clk);
        chk("hs_v1", bus.daq_valid, 1'b1);
        chk("hs_e1", bus.daq_end,   1'b0);
        @(negedge clk);
        chk("hs_v2", bus.daq_valid, 1'b1);
        chk("hs_e2", bus.daq_end,   1'b1);
        chk("hs_r2", bus.daq_req,   1'b1);
        @(negedge clk);
        chk("hs_v3", bus.daq_valid, 1'b0);
        chk("hs_e3", bus.daq_end,   1'b0);
        chk("hs_r3", bus.daq_req,   1'b0);
        repeat (3) @(negedge clk);

        // Drop counting at period 4
        bus.daq_grant = 0;
        arm(24'd4);
        wait_sig(40, "drop_req", 1'b0);
        repeat (50) @(negedge clk);
        bus.daq_grant = 1;
        enable = 0;
        wait_pkt(20, "drop_pkt1");
        chk("drop_cnt", {24'd0, last[0][23:16]}, 32'd12);
        arm(24'd20);
        wait_pkt(60, "drop_pkt2");
        chk("drop_cnt_next", {24'd0, last[0][23:16]}, 32'd0);
        enable = 0;
        repeat (3) @(negedge clk);

        // Drop counter saturation at period 1
        bus.daq_grant = 0;
        arm(24'd1);
        wait_sig(20, "sat_req", 1'b0);
        repeat (300) @(negedge clk);
        bus.daq_grant = 1;
        enable = 0;
        wait_pkt(20, "sat_pkt");
        chk("drop_sat", {24'd0, last[0][23:16]}, 32'd255);
        repeat (3) @(negedge clk);

        // zero colliding with a decoded step
        for (int i = 0; i < 3; i++) qstep(1);
        g = (g + 1) % 4;
        {enc_a, enc_b} = lut(g);
        repeat (2) @(negedge clk);
        zero = 1;
        @(negedge clk);
        zero = 0;
        repeat (8) @(negedge clk);
        arm(24'd20);
        repeat (19) @(negedge clk);
        #1 t_rec = systime;
        wait_pkt(40, "zero_pkt");
        chk("zero_w2", last[2], 32'd0);
        chk("zero_w1", last[1], t_rec);
        enable = 0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a packet
        arm(24'd20);
        wait_sig(100, "rst_w0", 1'b1);
        @(posedge clk);
        #2;
        chk("mid_valid_w1", bus.daq_valid, 1'b1);
        rst_n = 0;
        g = 0;
        {enc_a, enc_b} = 2'b00;
        #1;
        chk("mid_rst_valid", bus.daq_valid, 1'b0);
        chk("mid_rst_req",   bus.daq_req,   1'b0);
        chk("mid_rst_end",   bus.daq_end,   1'b0);
        chk("mid_rst_data",  bus.daq_data,  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_pkt(30, "post_rst_pkt");
        chk("post_rst_w0", last[0], 32'h1000_0000);
        chk("post_rst_w2", last[2], 32'd0);
        enable = 0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_daq.md
# quad_daq

Quadrature-encoder acquisition source for the DAQ arbiter. Decodes an A/B encoder into a 32-bit position counter. At a programmable sample period it snapshots position and `systime` and delivers a fixed 3-word packet through the DAQ req/grant stream, the same port set that `daq` arbitrates. Sits directly upstream of `daq` as one of its NDAQ channels.

## Interface
- `DAQ_ID`, 8'h10, channel tag placed in header word bits [31:24]
- `PERIOD_BITS`, 24, width of the sample-period input
- `clk` input 1: system clock (48 MHz), all logic on rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `systime` input 32: free-running system time, latched at sample
- `enc_a`, `enc_b` input 1 each: raw asynchronous encoder pins
- `enable` input 1: sampling enable (level)
- `period` input PERIOD_BITS: sample interval in clk cycles; 0 = no sampling
- `zero` input 1: single-cycle pulse, clears position
- `daq_data` output 32: packet word
- `daq_valid` output 1: `daq_data` valid this cycle
- `daq_end` output 1: last word of packet
- `daq_req` output 1: request for the DAQ stream
- `daq_grant` input 1: stream granted by arbiter

## Operation
- Synchronizer: `enc_a` and `enc_b` each pass through a 2-FF sync. A third register holds the previous synced {a,b}.
- 4x decode on {prev, cur}:
  - Gray-forward step 00→01→11→10→00 increments `pos`.
  - Reverse step decrements `pos`.
  - No change: no action.
  - Both bits changed: illegal. Sets sticky `err`; `pos` unchanged.
- `pos` is 32-bit two's complement and wraps modulo 2^32.
- `zero` forces `pos`=0 and wins over a simultaneous step.
- Timer:
  - While `enable`=0 or `period`=0, timer holds at `period`-1 and no samples occur.
  - Otherwise it counts down. At 0 it fires a sample tick and reloads `period`-1.
- Sample tick:
  - If no packet is pending or in flight: latch `snap_pos`=`pos` and `snap_time`=`systime` (both as of that cycle), then set `pending`.
  - Otherwise: discard the sample and increment the 8-bit saturating `drops`.
- Packet, 3 words, in order:
  - W0 = {DAQ_ID, drops[7:0], 15'd0, err}
  - W1 = snap_time
  - W2 = snap_pos
- `drops` and `err` are captured into W0 and cleared in the cycle W0 is emitted. An error or drop occurring in that same cycle is kept for the next packet.
- FSM (outputs registered), states IDLE, REQ, W0, W1, W2:
  - IDLE: `pending` → REQ.
  - REQ: `daq_req`=1 and waits for `daq_grant`; on grant → W0.
  - W0 → W1 → W2 → IDLE, unconditionally.
  - `pending` clears on the W2 cycle.
- Dropping `enable` does not abort a pending or in-flight packet; it completes normally.

## Timing
- Reset values: `daq_data`=0, `daq_valid`=0, `daq_end`=0, `daq_req`=0. Internal: `pos`=0, `err`=0, `drops`=0, `pending`=0, FSM=IDLE, timer=0, sync regs=0.
- Async reset mid-packet: outputs drop immediately, the packet is lost, no partial resend after release.
- Pin edge to `pos` update: 3 clk (2 sync + decode register).
- Sample tick at edge t → `daq_req`=1 from t+2 (pending at t+1, REQ at t+2).
- `daq_grant` sampled high at edge k:
  - W0 valid during k+1, W1 during k+2.
  - W2 during k+3, with `daq_end`=1.
  - k+4: `daq_valid`=`daq_end`=`daq_req`=0.
- `daq_req` stays high continuously from REQ through W2.
- `daq_valid` is contiguous for exactly 3 cycles; no gaps, no backpressure.
- `daq_grant` is ignored outside REQ.
- `period`=1: a tick every cycle. Packets go out back-to-back at the rate the arbiter allows; every sample taken while pending is counted in `drops`, saturating at 255.

## Test plan
- Forward/reverse count: 10 forward quadrature steps, then 3 reverse, pins toggling every 8 clk; `period`=1000 → `pos`=7. The next packet's W2 = 0x00000007, W0 = 0x10000000.
- Illegal transition and wrap: from `pos`=0, apply one reverse step, then a step with both A and B toggled → W2 = 0xFFFFFFFF and W0 bit0 = 1. The following packet has W0 bit0 = 0.
- Handshake timing: hold `daq_grant`=0 for 20 cycles after `daq_req` rises, then assert it → exactly 3 valid words starting the cycle after grant, `daq_end` only on the 3rd, and `daq_req` low the cycle after `daq_end`.
- Drop counting: `period`=4, grant withheld for 50 cycles → W0[23:16] = number of ticks during pending (12). The next packet shows drops=0 if granted promptly.
- `zero` collision: pulse `zero` in the same cycle as a decoded increment → `pos`=0 afterwards. W1 of the next packet equals `systime` at the tick cycle.
- Reset mid-packet: assert `rst_n`=0 during W1 → outputs low asynchronously. After release, the first packet has W0 = 0x10000000 and W2 = 0.
